// File: rtl/uart_pkg.sv
// UART shared package: line FSM states, default clock/baud, bit period helper.
// Used by both the receiver and the transmitter so they agree on the bit period.
package uart_pkg;

    localparam int unsigned UART_CLK_FREQ = 100_000_000;
    localparam int unsigned UART_BAUDRATE = 9600;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    // Clocks per bit, truncated the same way on both ends of the link.
    function automatic int unsigned bit_cycles(
        input int unsigned clk_freq,
        input int unsigned baud
    );
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: clk, rst_n (sync, active low), d_i (async in), q_o (synced out).
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready holding register.
// Ports: clk, rst_n (sync, active low), rx (async line), rx_data/rx_valid/
// rx_ready (byte handshake), rx_frame_err and rx_overrun (1-cycle pulses).
// Option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling
// (needs BIT_CYCLES >= 8; shifts all timing by one cycle).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = UART_CLK_FREQ,
    parameter int unsigned BAUDRATE    = UART_BAUDRATE,
    parameter int unsigned BIT_CYCLES  = bit_cycles(CLK_FREQ, BAUDRATE),
    parameter int unsigned HALF_CYCLES = BIT_CYCLES / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam logic [15:0] BIT_LAST = 16'(BIT_CYCLES - 1);

    logic rx_s;
    logic bit_s;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (rx),
        .q_o  (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Decision lands one cycle after the nominal sample point; the two
    // history flops hold the samples at target-1 and target.
    localparam logic [15:0] START_AT = 16'(HALF_CYCLES);

    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign bit_s = (hist_q[1] & hist_q[0]) |
                   (hist_q[1] & rx_s) |
                   (hist_q[0] & rx_s);
`else
    localparam logic [15:0] START_AT = 16'(HALF_CYCLES - 1);

    assign bit_s = rx_s;
`endif

    uart_state_e state_q;
    logic [15:0] cnt_q;
    logic [3:0]  idx_q;
    logic [7:0]  sh_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        ferr_q;
    logic        ovr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == START_AT) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        // A high start sample means a glitch, not a frame.
                        state_q <= bit_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        sh_q  <= {bit_s, sh_q[7:1]};
                        idx_q <= idx_q + 4'd1;
                        if (idx_q == 4'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (bit_s) begin
                            // Re-arm mid stop bit so the next start edge
                            // can follow immediately.
                            state_q <= IDLE;
                            if (valid_q && !rx_ready) begin
                                ovr_q <= 1'b1;
                            end else begin
                                data_q  <= sh_q;
                                valid_q <= 1'b1;
                            end
                        end else begin
                            state_q <= BREAK;
                            ferr_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: random frames against a byte-level model.
// Ports exercised: rx line, rx_data/rx_valid/rx_ready, error pulses.
module tb_uart_rx;

    localparam int BIT  = 16;
    localparam int HALF = BIT / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = HALF + 9 * BIT + 4;
`else
    localparam int LAT = HALF + 9 * BIT + 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;

    uart_rx #(
        .CLK_FREQ   (BIT * 1000),
        .BAUDRATE   (1000),
        .BIT_CYCLES (BIT),
        .HALF_CYCLES(HALF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int rise_cyc = -1;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int both_cnt = 0;
    int ferr_exp = 0;
    int ovr_exp = 0;
    logic vprev = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (rx_frame_err) ferr_cnt++;
            if (rx_overrun) ovr_cnt++;
            if (rx_frame_err && rx_overrun) both_cnt++;
            if (rx_valid && !vprev) rise_cyc = cyc;
            vprev = rx_valid;
        end else begin
            vprev = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(BIT);
    endtask

    task automatic send(input logic [7:0] b, input int nstop,
                        input logic stopv);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        for (int s = 0; s < nstop; s++) drive_bit(stopv);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!rx_valid && n < 20 * BIT) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(rx_valid), 32'd1);
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_n"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_b"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_fe"}, 32'(ferr_cnt), 32'(ferr_exp));
        chk({tag, "_ov"}, 32'(ovr_cnt), 32'(ovr_exp));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int t0;
        logic [7:0] b;
        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_fe", 32'(rx_frame_err), 32'd0);
        chk("rst_ov", 32'(rx_overrun), 32'd0);
        rst_n = 1'b1;
        tick(2 * BIT);

        // 0xA5, two stop bits, latency from rx pin
        t0 = cyc;
        send(8'hA5, 2, 1'b1);
        wait_valid("a5_valid");
        chk("a5_lat", 32'(rise_cyc - t0), 32'(LAT));
        chk("a5_data", 32'(rx_data), 32'hA5);
        rx_ready = 1'b1;
        tick(2);
        chk("a5_clr", 32'(rx_valid), 32'd0);
        exp_q.push_back(8'hA5);
        cmp_q("a5");

        // back-to-back, one stop bit
        send(8'h00, 1, 1'b1);
        send(8'hFF, 1, 1'b1);
        tick(2 * BIT);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        cmp_q("b2b");

        // short lows never reaching mid start bit
        for (int k = 0; k < 5; k++) begin
            rx = 1'b0;
            tick($urandom_range(HALF - 3, 1));
            rx = 1'b1;
            tick(2 * BIT);
        end
        chk("glitch_v", 32'(rx_valid), 32'd0);
        cmp_q("glitch");

        // bad stop then held low, then a clean frame
        send(8'h3C, 1, 1'b0);
        rx = 1'b0;
        tick(3 * BIT);
        rx = 1'b1;
        tick(2 * BIT);
        ferr_exp++;
        send(8'h12, 1, 1'b1);
        tick(2 * BIT);
        exp_q.push_back(8'h12);
        cmp_q("brk");

        // overrun with consumer stalled
        rx_ready = 1'b0;
        send(8'h11, 1, 1'b1);
        send(8'h22, 1, 1'b1);
        tick(BIT);
        chk("ovr_data", 32'(rx_data), 32'h11);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        ovr_exp++;
        rx_ready = 1'b1;
        tick(2);
        chk("ovr_clr", 32'(rx_valid), 32'd0);
        exp_q.push_back(8'h11);
        cmp_q("ovr");

        // reset during 4th data bit
        b = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        rx = b[3];
        tick(HALF);
        rst_n = 1'b0;
        tick(1);
        chk("mrst_valid", 32'(rx_valid), 32'd0);
        chk("mrst_data", 32'(rx_data), 32'd0);
        chk("mrst_fe", 32'(rx_frame_err), 32'd0);
        chk("mrst_ov", 32'(rx_overrun), 32'd0);
        rst_n = 1'b1;
        rx = 1'b1;
        tick(12 * BIT);
        cmp_q("mrst");
        send(8'h5A, 1, 1'b1);
        tick(2 * BIT);
        exp_q.push_back(8'h5A);
        cmp_q("mrst2");

        // random frames: stop count, bad stop, idle gap
        for (int k = 0; k < 24; k++) begin
            b = 8'($urandom());
            if ($urandom_range(5, 0) == 0) begin
                send(b, 1, 1'b0);
                rx = 1'b0;
                tick($urandom_range(2 * BIT, 1));
                rx = 1'b1;
                tick(BIT + 4);
                ferr_exp++;
            end else begin
                send(b, int'($urandom_range(2, 1)), 1'b1);
                exp_q.push_back(b);
                tick($urandom_range(BIT, 0));
            end
        end
        tick(2 * BIT);
        cmp_q("rand");

`ifdef UART_RX_MAJORITY_EN
        // one-cycle glitch at mid-bit of bit 3 of 0xF0
        rx_ready = 1'b0;
        b = 8'hF0;
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                rx = b[i];
                tick(HALF);
                rx = ~b[i];
                tick(1);
                rx = b[i];
                tick(BIT - HALF - 1);
            end else begin
                drive_bit(b[i]);
            end
        end
        rx = 1'b1;
        wait_valid("maj_valid");
        chk("maj_lat", 32'(rise_cyc - t0), 32'(LAT));
        chk("maj_data", 32'(rx_data), 32'hF0);
        rx_ready = 1'b1;
        tick(2 * BIT);
        exp_q.push_back(8'hF0);
        cmp_q("maj");
`endif

        chk("excl", 32'(both_cnt), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
